// File: rtl/tea_encrypt_core.sv
// Iterative TEA encryption: one combinational tea_round per clock, ROUNDS times per block.
// Block enters and ciphertext leaves over independent valid/ready handshakes.

module tea_round (
   input  logic [63:0]  idata,
   input  logic [31:0]  sum,
   input  logic [127:0] key,
   output logic [63:0]  odata
);
   logic [31:0] v0, v1, k0, k1, k2, k3;
   logic [31:0] v0_new, v1_new;

   assign v0 = idata[63:32];
   assign v1 = idata[31:0];
   assign k0 = key[127:96];
   assign k1 = key[95:64];
   assign k2 = key[63:32];
   assign k3 = key[31:0];

   // v1 half uses the already-updated v0, as in the reference algorithm
   assign v0_new = v0 + (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
   assign v1_new = v1 + (((v0_new << 4) + k2) ^ (v0_new + sum) ^ ((v0_new >> 5) + k3));

   assign odata = {v0_new, v1_new};
endmodule

module tea_encrypt_core #(
   parameter int unsigned ROUNDS = 32,
   parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  in_data,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_data,
   output logic         busy
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [7:0] LAST_CNT = 8'(ROUNDS - 1);

   logic [1:0]   state_q, state_d;
   logic [63:0]  data_q, data_d;
   logic [127:0] key_q, key_d;
   logic [31:0]  sum_q, sum_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         out_valid_q, out_valid_d;

   logic [31:0]  round_sum;
   logic [63:0]  round_odata;

   assign round_sum = sum_q + DELTA;

   tea_round u_round (
      .idata (data_q),
      .sum   (round_sum),
      .key   (key_q),
      .odata (round_odata)
   );

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      key_d       = key_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               key_d   = in_key;
               sum_d   = 32'd0;
               cnt_d   = 8'd0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            data_d = round_odata;
            sum_d  = round_sum;
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == LAST_CNT) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         data_q      <= 64'd0;
         key_q       <= 128'd0;
         sum_q       <= 32'd0;
         cnt_q       <= 8'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         key_q       <= key_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Status outputs decode straight from state so reset clears them without waiting for a clock
   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
   assign out_valid = out_valid_q;
   assign out_data  = data_q;
endmodule

// File: tb/tb_tea_encrypt_core.sv
// Randomized bench for tea_encrypt_core: a cycle-level behavioural model built on a plain
// TEA reference function is compared against the DUT on every falling clock edge.

module tb_tea_encrypt_core;
   localparam logic [31:0] DELTA = 32'h9E3779B9;
   localparam logic [63:0] ZERO_CT  = 64'h41EA3A0A_94BAA940;
   localparam logic [63:0] ONE_RND  = 64'h9E3779B9_DBE8D32F;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic [63:0]  in_data = 64'd0;
   logic [127:0] in_key = 128'd0;
   logic         in_ready, out_valid, busy, out_ready;
   logic [63:0]  out_data;
   logic         rnd_ready = 1'b0, rnd_val = 1'b0, fix_ready = 1'b1;

   logic         in1_valid = 1'b0;
   logic         in1_ready, out1_valid, busy1;
   logic [63:0]  out1_data;
   logic         out1_ready = 1'b1;

   int tests = 0, fails = 0, cyc = 0, n_hs = 0;
   logic chk_en = 1'b0, cnt_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign out_ready = rnd_ready ? rnd_val : fix_ready;
   always @(posedge clk) begin
      #1 rnd_val = ($urandom_range(0, 2) != 0);
   end

   tea_encrypt_core dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   tea_encrypt_core #(.ROUNDS(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready),
      .in_data(64'd0), .in_key(128'd0), .out_valid(out1_valid),
      .out_ready(out1_ready), .out_data(out1_data), .busy(busy1)
   );

   function automatic logic [63:0] tea_ref(logic [63:0] p, logic [127:0] k, int n);
      logic [31:0] v0, v1, s;
      v0 = p[63:32];
      v1 = p[31:0];
      s  = 32'd0;
      for (int i = 0; i < n; i++) begin
         s  = s + DELTA;
         v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
         v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
      end
      return {v0, v1};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a block is busy from accept until its result is taken; the result
   // appears exactly 32 edges after the accepting edge.
   logic        m_busy = 1'b0, m_ov = 1'b0;
   int          m_left = 0;
   logic [63:0] m_res = 64'd0, m_data = 64'd0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 1'b0;
         m_ov   <= 1'b0;
         m_left <= 0;
         m_data <= 64'd0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy <= 1'b1;
            m_left <= 32;
            m_res  <= tea_ref(in_data, in_key, 32);
         end
      end else if (m_ov) begin
         if (out_ready) begin
            m_ov   <= 1'b0;
            m_busy <= 1'b0;
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_ov   <= 1'b1;
            m_data <= m_res;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", {63'd0, in_ready}, {63'd0, !m_busy});
         chk("busy", {63'd0, busy}, {63'd0, m_busy});
         chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
         if (m_ov) chk("out_data", out_data, m_data);
         if (!rst) chk("rst_out_data", out_data, 64'd0);
         if (cnt_en && out_valid && out_ready) n_hs++;
      end
   end

   task automatic send(input logic [63:0] d, input logic [127:0] k, input bit hold, output int acc);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_key   = k;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      acc = cyc;
      if (!hold) begin
         in_valid = 1'b0;
         in_data  = {$urandom, $urandom};
         in_key   = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic wait_out(output int c);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("out_timeout", 64'd0, 64'd1);
      c = cyc;
   endtask

   initial begin
      int a, a2, c, n;
      logic [63:0]  p;
      logic [127:0] k;

      chk("ref_zero", tea_ref(64'd0, 128'd0, 32), ZERO_CT);
      chk("ref_one", tea_ref(64'd0, 128'd0, 1), ONE_RND);

      @(posedge clk);
      #1 chk_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset_out_data", out_data, 64'd0);
      #1 rst = 1'b1;

      // Zero key/plaintext, consumer always ready
      send(64'd0, 128'd0, 1'b0, a);
      wait_out(c);
      chk("latency", 64'(c - a), 64'd32);
      chk("zero_vec", out_data, ZERO_CT);

      // Same block, consumer stalls 10 cycles
      repeat (2) @(posedge clk);
      #1 fix_ready = 1'b0;
      send(64'd0, 128'd0, 1'b0, a);
      wait_out(c);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_data", out_data, ZERO_CT);
         chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk);
      #1 fix_ready = 1'b1;
      @(negedge clk);
      chk("release_valid", {63'd0, out_valid}, 64'd1);
      @(negedge clk);
      chk("release_in_ready", {63'd0, in_ready}, 64'd1);

      // Back-to-back with in_valid held high
      p = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      send(p, k, 1'b1, a);
      send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, a2);
      chk("b2b_gap", 64'(a2 - a), 64'd34);
      wait_out(c);

      // Reset in the middle of a run
      @(posedge clk);
      #1;
      send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, a);
      repeat (15) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_in_ready", {63'd0, in_ready}, 64'd1);
      chk("async_out_valid", {63'd0, out_valid}, 64'd0);
      chk("async_busy", {63'd0, busy}, 64'd0);
      chk("async_out_data", out_data, 64'd0);
      @(negedge clk);
      #1 rst = 1'b1;
      p = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      send(p, k, 1'b0, a);
      wait_out(c);
      chk("post_reset_ct", out_data, tea_ref(p, k, 32));
      chk("post_reset_latency", 64'(c - a), 64'd32);

      // Single-round instance
      @(posedge clk);
      #1 in1_valid = 1'b1;
      @(negedge clk);
      chk("r1_in_ready", {63'd0, in1_ready}, 64'd1);
      @(posedge clk);
      #1 in1_valid = 1'b0;
      @(negedge clk);
      chk("r1_early", {63'd0, out1_valid}, 64'd0);
      @(negedge clk);
      chk("r1_valid", {63'd0, out1_valid}, 64'd1);
      chk("r1_data", out1_data, ONE_RND);

      // Random vectors with random consumer stalls
      @(posedge clk);
      #1;
      rnd_ready = 1'b1;
      cnt_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, a);
      end
      n = 0;
      while (m_busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_done", {63'd0, m_busy}, 64'd0);
      @(negedge clk);
      chk("hs_count", 64'(n_hs), 64'd100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
